// File: rtl/sd_fifo_arb.sv
// rtl/sd_fifo_arb.sv - round-robin write-side arbiter for a shared srdy/drdy FIFO
// Build option: define SDLIB_ARB_LOCK_EN to hold a grant until the winner's
// end-of-packet beat transfers (packet locking). Undefined, every beat is
// arbitrated independently and the pointer advances after each transfer.
module sd_fifo_arb #(
   parameter int width  = 8,
   parameter int inputs = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [inputs-1:0]         c_srdy,
   output logic [inputs-1:0]         c_drdy,
   input  logic [inputs*width-1:0]   c_data,
   input  logic [inputs-1:0]         c_eop,
   output logic                      p_srdy,
   input  logic                      p_drdy,
   output logic [width-1:0]          p_data,
   output logic                      p_eop,
   output logic [inputs-1:0]         p_grant
);

   localparam int PW = (inputs > 1) ? $clog2(inputs) : 1;
   localparam logic [PW-1:0] LAST = PW'(inputs - 1);

   // priority pointer and output stage
   logic [PW-1:0]     ptr_q, ptr_d;
   logic              p_srdy_q, p_srdy_d;
   logic [width-1:0]  p_data_q, p_data_d;
   logic              p_eop_q, p_eop_d;
   logic [inputs-1:0] p_grant_q, p_grant_d;

   // arbitration results
   logic [PW-1:0]     rr_win;
   logic              rr_any;
   logic [PW-1:0]     win;
   logic [PW-1:0]     win_inc;
   logic              any;
   logic              ld;
   logic              xfer;

   // the output register can take a new beat when empty or being drained
   assign ld = ~p_srdy_q | p_drdy;

   // a beat moves only when someone is selected and the stage can load;
   // reset blocks acceptance so nothing is lost while the stage is cleared
   assign xfer = any & ld & ~reset;

   // wrap at inputs-1, not at 2^PW, so non-power-of-2 counts stay in range
   assign win_inc = (win == LAST) ? '0 : win + PW'(1);

   // round-robin search from ptr: scan downward so the nearest requester wins last
   always_comb begin
      int t;
      rr_win = '0;
      rr_any = 1'b0;
      t      = 0;
      for (int j = inputs - 1; j >= 0; j--) begin
         t = int'(ptr_q) + j;
         if (t >= inputs) t = t - inputs;
         if (c_srdy[t]) begin
            rr_any = 1'b1;
            rr_win = PW'(t);
         end
      end
   end

`ifdef SDLIB_ARB_LOCK_EN
   typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] lock_q, lock_d;

   // state register: FSM state, locked source and pointer
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         lock_q  <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         lock_q  <= lock_d;
         ptr_q   <= ptr_d;
      end
   end

   // next state: a non-eop beat locks onto its source, an eop beat releases it
   always_comb begin
      state_d = state_q;
      lock_d  = lock_q;
      ptr_d   = ptr_q;
      if (xfer) begin
         if (c_eop[win]) begin
            state_d = IDLE;
            ptr_d   = win_inc;
         end else begin
            state_d = LOCK;
            lock_d  = win;
         end
      end
   end

   // selection: while locked only the owner may be chosen, even when it is idle
   always_comb begin
      win = rr_win;
      any = rr_any;
      if (state_q == LOCK) begin
         win = lock_q;
         any = c_srdy[lock_q];
      end
   end
`else
   // pointer register: advances past the winner after every transfer
   always_ff @(posedge clk) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

   // next pointer and selection with no packet locking
   always_comb begin
      win   = rr_win;
      any   = rr_any;
      ptr_d = xfer ? win_inc : ptr_q;
   end
`endif

   // accept strobe: only the winner sees drdy, and only when a beat moves
   always_comb begin
      c_drdy = '0;
      for (int i = 0; i < inputs; i++) begin
         c_drdy[i] = xfer && (win == PW'(i));
      end
   end

   // output stage next values: load on transfer, empty when loading nothing
   always_comb begin
      p_srdy_d  = p_srdy_q;
      p_data_d  = p_data_q;
      p_eop_d   = p_eop_q;
      p_grant_d = p_grant_q;
      if (ld) begin
         p_srdy_d = xfer;
      end
      if (xfer) begin
         p_data_d  = c_data[int'(win)*width +: width];
         p_eop_d   = c_eop[win];
         p_grant_d = c_drdy;
      end
   end

   // output stage registers
   always_ff @(posedge clk) begin
      if (reset) begin
         p_srdy_q  <= 1'b0;
         p_data_q  <= '0;
         p_eop_q   <= 1'b0;
         p_grant_q <= '0;
      end else begin
         p_srdy_q  <= p_srdy_d;
         p_data_q  <= p_data_d;
         p_eop_q   <= p_eop_d;
         p_grant_q <= p_grant_d;
      end
   end

   assign p_srdy  = p_srdy_q;
   assign p_data  = p_data_q;
   assign p_eop   = p_eop_q;
   assign p_grant = p_grant_q;

endmodule

// File: tb/tb_sd_fifo_arb.sv
// tb/tb_sd_fifo_arb.sv - directed vector bench for sd_fifo_arb (4 inputs, 8-bit data)
module tb_sd_fifo_arb;

   localparam int W = 8;
   localparam int N = 4;

   logic           clk;
   logic           reset;
   logic [N-1:0]   c_srdy;
   logic [N-1:0]   c_drdy;
   logic [N*W-1:0] c_data;
   logic [N-1:0]   c_eop;
   logic           p_srdy;
   logic           p_drdy;
   logic [W-1:0]   p_data;
   logic           p_eop;
   logic [N-1:0]   p_grant;

   sd_fifo_arb #(.width(W), .inputs(N)) dut (
      .clk     (clk),
      .reset   (reset),
      .c_srdy  (c_srdy),
      .c_drdy  (c_drdy),
      .c_data  (c_data),
      .c_eop   (c_eop),
      .p_srdy  (p_srdy),
      .p_drdy  (p_drdy),
      .p_data  (p_data),
      .p_eop   (p_eop),
      .p_grant (p_grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // inputs for one cycle, and the outputs expected just before that cycle's edge:
   // c_drdy is this cycle's combinational accept, p_* are from earlier edges.
   // Source i carries data {i, dn}.
   typedef struct {
      logic         rst;
      logic [N-1:0] srdy;
      logic [N-1:0] eop;
      logic         pdrdy;
      logic [3:0]   dn;
      logic [N-1:0] x_drdy;
      logic         x_psrdy;
      logic [N-1:0] x_grant;
      logic [W-1:0] x_data;
      logic         x_eop;
   } vec_t;

   vec_t vecs[$];
   int   applied;
   int   miscompares;

   function automatic vec_t mk(input logic rst, input logic [3:0] srdy, input logic [3:0] eop,
                               input logic pdrdy, input logic [3:0] dn, input logic [3:0] x_drdy,
                               input logic x_psrdy, input logic [3:0] x_grant,
                               input logic [7:0] x_data, input logic x_eop);
      vec_t v;
      v.rst = rst; v.srdy = srdy; v.eop = eop; v.pdrdy = pdrdy; v.dn = dn;
      v.x_drdy = x_drdy; v.x_psrdy = x_psrdy; v.x_grant = x_grant;
      v.x_data = x_data; v.x_eop = x_eop;
      return v;
   endfunction

   initial begin
      // common prefix: reset, round-robin of 1-beat packets, then a 3-cycle stall
      vecs.push_back(mk(1, 4'hF, 4'hF, 1, 4'h0, 4'h0, 0, 4'h0, 8'h00, 0)); // v0 reset
      vecs.push_back(mk(0, 4'hF, 4'hF, 1, 4'h1, 4'h1, 0, 4'h0, 8'h00, 0)); // v1
      vecs.push_back(mk(0, 4'hF, 4'hF, 1, 4'h2, 4'h2, 1, 4'h1, 8'h01, 1)); // v2
      vecs.push_back(mk(0, 4'hF, 4'hF, 1, 4'h3, 4'h4, 1, 4'h2, 8'h12, 1)); // v3
      vecs.push_back(mk(0, 4'hF, 4'hF, 1, 4'h4, 4'h8, 1, 4'h4, 8'h23, 1)); // v4
      vecs.push_back(mk(0, 4'hF, 4'hF, 1, 4'h5, 4'h1, 1, 4'h8, 8'h34, 1)); // v5
      vecs.push_back(mk(0, 4'h0, 4'hF, 1, 4'h6, 4'h0, 1, 4'h1, 8'h05, 1)); // v6
      vecs.push_back(mk(0, 4'h0, 4'hF, 1, 4'h7, 4'h0, 0, 4'h1, 8'h05, 1)); // v7
      vecs.push_back(mk(0, 4'h4, 4'hF, 1, 4'h8, 4'h4, 0, 4'h1, 8'h05, 1)); // v8
      vecs.push_back(mk(0, 4'h3, 4'hF, 0, 4'h9, 4'h0, 1, 4'h4, 8'h28, 1)); // v9 stall
      vecs.push_back(mk(0, 4'h3, 4'hF, 0, 4'hA, 4'h0, 1, 4'h4, 8'h28, 1)); // v10 stall
      vecs.push_back(mk(0, 4'h3, 4'hF, 0, 4'hB, 4'h0, 1, 4'h4, 8'h28, 1)); // v11 stall
      vecs.push_back(mk(0, 4'h3, 4'hF, 1, 4'hC, 4'h1, 1, 4'h4, 8'h28, 1)); // v12 release
      vecs.push_back(mk(0, 4'h0, 4'hF, 1, 4'hD, 4'h0, 1, 4'h1, 8'h0C, 1)); // v13
      vecs.push_back(mk(0, 4'h0, 4'hF, 1, 4'hE, 4'h0, 0, 4'h1, 8'h0C, 1)); // v14
`ifdef SDLIB_ARB_LOCK_EN
      // req 1 sends 3 beats with a 2-cycle gap, req 0 and 2 wait; then reset mid-packet
      vecs.push_back(mk(0, 4'h7, 4'h5, 1, 4'hF, 4'h2, 0, 4'h1, 8'h0C, 1)); // v15
      vecs.push_back(mk(0, 4'h7, 4'h5, 1, 4'h0, 4'h2, 1, 4'h2, 8'h1F, 0)); // v16 locked
      vecs.push_back(mk(0, 4'h5, 4'h5, 1, 4'h1, 4'h0, 1, 4'h2, 8'h10, 0)); // v17 gap
      vecs.push_back(mk(0, 4'h5, 4'h5, 1, 4'h2, 4'h0, 0, 4'h2, 8'h10, 0)); // v18 gap
      vecs.push_back(mk(0, 4'h7, 4'h7, 1, 4'h3, 4'h2, 0, 4'h2, 8'h10, 0)); // v19 last beat
      vecs.push_back(mk(0, 4'h7, 4'h7, 1, 4'h4, 4'h4, 1, 4'h2, 8'h13, 1)); // v20
      vecs.push_back(mk(0, 4'h7, 4'hF, 1, 4'h5, 4'h1, 1, 4'h4, 8'h24, 1)); // v21
      vecs.push_back(mk(0, 4'h0, 4'hF, 1, 4'h6, 4'h0, 1, 4'h1, 8'h05, 1)); // v22
      vecs.push_back(mk(0, 4'h2, 4'h0, 1, 4'h7, 4'h2, 0, 4'h1, 8'h05, 1)); // v23 lock src 1
      vecs.push_back(mk(1, 4'h3, 4'h0, 1, 4'h8, 4'h0, 1, 4'h2, 8'h17, 0)); // v24 reset
      vecs.push_back(mk(0, 4'h3, 4'h0, 1, 4'h9, 4'h1, 0, 4'h0, 8'h00, 0)); // v25 idle, ptr 0
      vecs.push_back(mk(0, 4'h0, 4'h0, 1, 4'hA, 4'h0, 1, 4'h1, 8'h09, 0)); // v26
`else
      // same 3-beat stimulus interleaves 1,2,0,1; then reset mid-stream
      vecs.push_back(mk(0, 4'h7, 4'h5, 1, 4'hF, 4'h2, 0, 4'h1, 8'h0C, 1)); // v15
      vecs.push_back(mk(0, 4'h7, 4'h5, 1, 4'h0, 4'h4, 1, 4'h2, 8'h1F, 0)); // v16
      vecs.push_back(mk(0, 4'h7, 4'h5, 1, 4'h1, 4'h1, 1, 4'h4, 8'h20, 1)); // v17
      vecs.push_back(mk(0, 4'h7, 4'h5, 1, 4'h2, 4'h2, 1, 4'h1, 8'h01, 1)); // v18
      vecs.push_back(mk(0, 4'h7, 4'h7, 1, 4'h3, 4'h4, 1, 4'h2, 8'h12, 0)); // v19
      vecs.push_back(mk(1, 4'h7, 4'hF, 1, 4'h4, 4'h0, 1, 4'h4, 8'h23, 1)); // v20 reset
      vecs.push_back(mk(0, 4'h7, 4'hF, 1, 4'h5, 4'h1, 0, 4'h0, 8'h00, 0)); // v21 ptr 0
      vecs.push_back(mk(0, 4'h0, 4'hF, 1, 4'h6, 4'h0, 1, 4'h1, 8'h05, 1)); // v22
`endif
   end

   task automatic drive(input vec_t v);
      reset  = v.rst;
      c_srdy = v.srdy;
      c_eop  = v.eop;
      p_drdy = v.pdrdy;
      for (int i = 0; i < N; i++) c_data[i*W +: W] = {4'(i), v.dn};
   endtask

   initial begin
      applied     = 0;
      miscompares = 0;
      reset  = 1'b1;
      c_srdy = '0;
      c_eop  = '0;
      c_data = '0;
      p_drdy = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      for (int k = 0; k < vecs.size(); k++) begin
         @(negedge clk);
         drive(vecs[k]);
         #2;
         applied++;
         if (c_drdy !== vecs[k].x_drdy || p_srdy !== vecs[k].x_psrdy ||
             p_grant !== vecs[k].x_grant || p_data !== vecs[k].x_data ||
             p_eop !== vecs[k].x_eop) begin
            miscompares++;
            $display("FAIL vec%0d: got drdy=%b srdy=%b grant=%b data=%h eop=%b, want drdy=%b srdy=%b grant=%b data=%h eop=%b",
                     k, c_drdy, p_srdy, p_grant, p_data, p_eop,
                     vecs[k].x_drdy, vecs[k].x_psrdy, vecs[k].x_grant,
                     vecs[k].x_data, vecs[k].x_eop);
         end
      end
      @(negedge clk);
      if (applied != vecs.size()) begin
         miscompares++;
         $display("FAIL applied %0d of %0d vectors", applied, vecs.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      if (miscompares == 0) $display("PASS");
      else                  $display("FAIL %0d miscompares", miscompares);
      $finish;
   end

   // absolute time bound so a broken build can never hang the run
   initial begin
      #20000;
      $display("FAIL timeout: vector loop still running, required completion");
      $fatal(1, "timeout");
   end

endmodule
